// File: rtl/tanh_interp_sched_if.sv
// Bundle of every handshake, LUT and interpolator signal of tanh_interp_sched.
//
// The modports are named from the scheduler's point of view:
//   slave  - the scheduler itself
//   master - the surroundings: requesters, breakpoint LUT, interpolator and consumer
//
// Signal summary:
//   req_valid / req_x / req_ready     requester side, one lane per requester, x is 8-bit signed
//   lut_en / lut_addr / lut_rdata     synchronous breakpoint LUT, data one cycle after lut_en
//   interp_base / interp_next /
//   interp_change / interp_remaining  registered operands to the combinational interpolator
//   interp_value                      interpolator result
//   resp_valid / resp_ready /
//   resp_data / resp_id               tagged result towards the consumer
//   busy                              scheduler is not idle
interface tanh_interp_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ-1:0]   req_ready;

  logic                 lut_en;
  logic [4:0]           lut_addr;
  logic signed [7:0]    lut_rdata;

  logic signed [7:0]    interp_base;
  logic signed [7:0]    interp_next;
  logic signed [7:0]    interp_change;
  logic signed [7:0]    interp_remaining;
  logic signed [7:0]    interp_value;

  logic                 resp_valid;
  logic                 resp_ready;
  logic signed [7:0]    resp_data;
  logic [ID_W-1:0]      resp_id;

  logic                 busy;

  modport slave (
    input  req_valid, req_x, lut_rdata, interp_value, resp_ready,
    output req_ready, lut_en, lut_addr,
    output interp_base, interp_next, interp_change, interp_remaining,
    output resp_valid, resp_data, resp_id, busy
  );

  modport master (
    output req_valid, req_x, lut_rdata, interp_value, resp_ready,
    input  req_ready, lut_en, lut_addr,
    input  interp_base, interp_next, interp_change, interp_remaining,
    input  resp_valid, resp_data, resp_id, busy
  );

endinterface

// File: rtl/tanh_interp_sched.sv
// Shares one piecewise-linear tanh interpolator among NUM_REQ requesters.
//
// Per request: round-robin grant, split x into segment and 4-bit fraction, two sequential
// reads of the breakpoint LUT (base, then next), drive the interpolator with registered
// operands for one cycle, then hold the tagged result until the consumer takes it.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - tanh_interp_sched_if.slave (requesters, LUT, interpolator, response, busy)
//
// Optional build macro:
//   TANH_SYM_EN - use the odd symmetry of tanh: look up |x| in a 9-entry LUT and negate
//                 the interpolated value for negative inputs. Undefined: 17-entry signed LUT.
//
// Timing: grant in cycle T (IDLE), FETCH_NEXT T+1, WAIT_NEXT T+2, CALC T+3, RESP from T+4.
module tanh_interp_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic                clk,
  input logic                rst,
  tanh_interp_sched_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchNext,
    StWaitNext,
    StCalc,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [7:0]        x_q, x_d;
  logic signed [7:0] base_q, base_d;
  logic signed [7:0] ib_q, ib_d;
  logic signed [7:0] in_q, in_d;
  logic signed [7:0] ic_q, ic_d;
  logic signed [7:0] ir_q, ir_d;
  logic signed [7:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
`ifdef TANH_SYM_EN
  logic              neg_q, neg_d;
`endif

  logic [NUM_REQ-1:0] req_ready;
  logic               lut_en;
  logic [4:0]         lut_addr;

  logic               found;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    cand;
  logic [7:0]         pick_x;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
`ifdef TANH_SYM_EN
  // |x|, with -128 folded onto 127 so the magnitude always fits in 7 bits.
  function automatic logic [7:0] sym_mag(input logic [7:0] x);
    if (x == 8'h80) begin
      return 8'h7f;
    end else if (x[7]) begin
      return (~x) + 8'd1;
    end
    return x;
  endfunction
`endif

  // LUT address of the lower breakpoint of the segment holding x.
  function automatic logic [4:0] seg_addr(input logic [7:0] x);
`ifdef TANH_SYM_EN
    logic [7:0] mag;
    mag = sym_mag(x);
    return {2'b00, mag[6:4]};
`else
    // idx + 8 for a 4-bit two's-complement idx is idx with its sign bit flipped.
    return {1'b0, ~x[7], x[6:4]};
`endif
  endfunction

  // Fraction within the segment, zero-extended to 8 bits.
  function automatic logic [7:0] seg_rem(input logic [7:0] x);
`ifdef TANH_SYM_EN
    logic [7:0] mag;
    mag = sym_mag(x);
    return {4'b0000, mag[3:0]};
`else
    return {4'b0000, x[3:0]};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester after the last one served.
  // ---------------------------------------------------------------------------
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_x = bus.req_x[{pick, 3'b000} +: 8];

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    x_d         = x_q;
    base_d      = base_q;
    ib_d        = ib_q;
    in_d        = in_q;
    ic_d        = ic_q;
    ir_d        = ir_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
`ifdef TANH_SYM_EN
    neg_d       = neg_q;
`endif
    req_ready   = '0;
    lut_en      = 1'b0;
    lut_addr    = '0;

    case (state_q)
      StIdle: begin
        // No acceptance while reset is held: the grant would be lost with the state.
        if (found && !rst) begin
          req_ready[pick] = 1'b1;
          x_d             = pick_x;
          gnt_id_d        = pick;
          rr_ptr_d        = pick;
`ifdef TANH_SYM_EN
          neg_d           = pick_x[7];
`endif
          lut_en          = 1'b1;
          lut_addr        = seg_addr(pick_x);
          state_d         = StFetchNext;
        end
      end

      StFetchNext: begin
        base_d   = bus.lut_rdata;
        lut_en   = 1'b1;
        lut_addr = seg_addr(x_q) + 5'd1;
        state_d  = StWaitNext;
      end

      StWaitNext: begin
        // Interpolator operands all change together on entry to CALC and hold after it.
        ib_d    = base_q;
        in_d    = bus.lut_rdata;
        ic_d    = bus.lut_rdata - base_q;
        ir_d    = seg_rem(x_q);
        state_d = StCalc;
      end

      StCalc: begin
`ifdef TANH_SYM_EN
        resp_data_d = neg_q ? -bus.interp_value : bus.interp_value;
`else
        resp_data_d = bus.interp_value;
`endif
        resp_id_d   = gnt_id_q;
        state_d     = StResp;
      end

      StResp: begin
        // Return to IDLE only; the next grant is made from IDLE one cycle later.
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      x_q         <= '0;
      base_q      <= '0;
      ib_q        <= '0;
      in_q        <= '0;
      ic_q        <= '0;
      ir_q        <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
`ifdef TANH_SYM_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      x_q         <= x_d;
      base_q      <= base_d;
      ib_q        <= ib_d;
      in_q        <= in_d;
      ic_q        <= ic_d;
      ir_q        <= ir_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
`ifdef TANH_SYM_EN
      neg_q       <= neg_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign bus.req_ready        = req_ready;
  assign bus.lut_en           = lut_en;
  assign bus.lut_addr         = lut_addr;
  assign bus.interp_base      = ib_q;
  assign bus.interp_next      = in_q;
  assign bus.interp_change    = ic_q;
  assign bus.interp_remaining = ir_q;
  assign bus.resp_valid       = (state_q == StResp);
  assign bus.resp_data        = resp_data_q;
  assign bus.resp_id          = resp_id_q;
  assign bus.busy             = (state_q != StIdle);

endmodule

// File: tb/tb_tanh_interp_sched.sv
// Self-checking bench for tanh_interp_sched: directed steps followed by randomized rounds,
// all expected values taken from a plain-arithmetic reference model of the tanh lookup.
module tb_tanh_interp_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  tanh_interp_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  tanh_interp_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Breakpoint LUT with one cycle read latency.
  logic signed [7:0] lut_mem [0:31];
  always_ff @(posedge clk) begin
    if (bus.lut_en) bus.lut_rdata <= lut_mem[bus.lut_addr];
  end

  // Interpolator: base + ((next - base) * remaining) >> 4.
  int ip_prod;
  always_comb begin
    ip_prod          = int'(bus.interp_change) * int'(bus.interp_remaining);
    bus.interp_value = 8'(int'(bus.interp_base) + (ip_prod >>> 4));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  // Reference: LUT address, fraction and final result for input x.
  function automatic void ref_model(input logic [7:0] x, output int a0, output int rem,
                                    output logic signed [7:0] y);
    int xi, b, n, ch, r;
`ifdef TANH_SYM_EN
    int mag;
`endif
    xi = int'($signed(x));
`ifdef TANH_SYM_EN
    mag = (xi < 0) ? ((xi == -128) ? 127 : -xi) : xi;
    a0  = mag / 16;
    rem = mag % 16;
`else
    a0  = (xi >>> 4) + 8;
    rem = xi - (xi >>> 4) * 16;
`endif
    b  = int'(lut_mem[a0]);
    n  = int'(lut_mem[a0 + 1]);
    ch = wrap8(n - b);
    r  = wrap8(b + ((ch * rem) >>> 4));
`ifdef TANH_SYM_EN
    if (xi < 0) r = wrap8(-r);
`endif
    y = 8'(r);
  endfunction

  // Waits (bounded) for a grant, expects requester id, then follows the request to RESP.
  task automatic run_req(input int id, input logic [7:0] x, input bit keep, input bit has_spec,
                         input logic signed [7:0] spec_data, output int gcyc);
    int a0, rem;
    logic signed [7:0] ed, ec;
    bit ok;
    ref_model(x, a0, rem, ed);
    ec = lut_mem[a0 + 1] - lut_mem[a0];
    ok = 1'b0;
    #1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.req_ready != '0) ok = 1'b1;
      else step();
    end
    gcyc = cyc;
    chk("req_ready", 32'(bus.req_ready), 32'(1) << id);
    chk("lut_en_base", 32'(bus.lut_en), 32'(1));
    chk("lut_addr_base", 32'(bus.lut_addr), 32'(a0));
    step();
    if (!keep) bus.req_valid = '0;
    chk("lut_en_next", 32'(bus.lut_en), 32'(1));
    chk("lut_addr_next", 32'(bus.lut_addr), 32'(a0 + 1));
    chk("busy", 32'(bus.busy), 32'(1));
    step();
    chk("lut_en_wait", 32'(bus.lut_en), 32'(0));
    step();
    chk("interp_base", 32'(bus.interp_base), 32'(lut_mem[a0]));
    chk("interp_next", 32'(bus.interp_next), 32'(lut_mem[a0 + 1]));
    chk("interp_change", 32'(bus.interp_change), 32'(ec));
    chk("interp_remaining", 32'(bus.interp_remaining), 32'(rem));
    chk("resp_valid_calc", 32'(bus.resp_valid), 32'(0));
    step();
    chk("resp_valid", 32'(bus.resp_valid), 32'(1));
    chk("resp_data", 32'(bus.resp_data), 32'(ed));
    chk("resp_id", 32'(bus.resp_id), 32'(id));
    if (has_spec) chk("resp_data_spec", 32'(bus.resp_data), 32'(spec_data));
  endtask

  initial begin
    logic [7:0] xs [NUM_REQ];
    logic [NUM_REQ-1:0] mask;
    logic signed [7:0] ed;
    int gc, prev_gc, hc, a0, rem, exp_ptr, pk, w;

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom);
`ifdef TANH_SYM_EN
    lut_mem[1] = 8'sd30;
    lut_mem[2] = 8'sd50;
    lut_mem[7] = 8'sd100;
    lut_mem[8] = 8'sd120;
`else
    lut_mem[9]  = 8'sd32;
    lut_mem[10] = 8'sd48;
    lut_mem[6]  = -8'sd48;
    lut_mem[7]  = -8'sd16;
`endif

    // Reset state; a request held during reset must not be accepted.
    step();
    step();
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("rst_lut_en", 32'(bus.lut_en), 32'(0));
    chk("rst_lut_addr", 32'(bus.lut_addr), 32'(0));
    chk("rst_resp_data", 32'(bus.resp_data), 32'(0));
    chk("rst_resp_id", 32'(bus.resp_id), 32'(0));
    chk("rst_interp_base", 32'(bus.interp_base), 32'(0));
    chk("rst_interp_rem", 32'(bus.interp_remaining), 32'(0));
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // Directed single requests.
`ifdef TANH_SYM_EN
    bus.req_x[0 +: 8] = 8'h13;
    bus.req_valid = 4'b0001;
    run_req(0, 8'h13, 1'b0, 1'b1, 8'sd33, gc);
    step();
    bus.req_x[24 +: 8] = 8'hE8;
    bus.req_valid = 4'b1000;
    run_req(3, 8'hE8, 1'b0, 1'b1, -8'sd40, gc);
    step();
    bus.req_x[16 +: 8] = 8'h80;
    bus.req_valid = 4'b0100;
    run_req(2, 8'h80, 1'b0, 1'b1, -8'sd118, gc);
    step();
`else
    bus.req_x[0 +: 8] = 8'h13;
    bus.req_valid = 4'b0001;
    run_req(0, 8'h13, 1'b0, 1'b1, 8'sd35, gc);
    step();
    bus.req_x[24 +: 8] = 8'hE8;
    bus.req_valid = 4'b1000;
    run_req(3, 8'hE8, 1'b0, 1'b1, -8'sd32, gc);
    step();
`endif

    // Backpressure: result held, no grant while in RESP, grant right after the handshake.
    bus.resp_ready = 1'b0;
    xs[2] = 8'($urandom);
    bus.req_x[16 +: 8] = xs[2];
    bus.req_valid = 4'b0100;
    run_req(2, xs[2], 1'b0, 1'b0, 8'sd0, gc);
    ref_model(xs[2], a0, rem, ed);
    xs[1] = 8'($urandom);
    bus.req_x[8 +: 8] = xs[1];
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'(1));
      chk("bp_resp_data", 32'(bus.resp_data), 32'(ed));
      chk("bp_resp_id", 32'(bus.resp_id), 32'(2));
      chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle_grant", 32'(bus.req_ready), 32'(0));
    hc = cyc;
    run_req(1, xs[1], 1'b0, 1'b0, 8'sd0, gc);
    chk("bp_grant_delay", 32'(gc - hc), 32'(1));

    // Round-robin from reset with everyone requesting.
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      xs[i] = 8'($urandom);
      bus.req_x[8*i +: 8] = xs[i];
    end
    bus.req_valid = 4'b1111;
    step();
    step();
    rst = 1'b0;
    prev_gc = 0;
    for (int g = 0; g < 5; g++) begin
      run_req(g % NUM_REQ, xs[g % NUM_REQ], 1'b1, 1'b0, 8'sd0, gc);
      if (g > 0) chk("rr_spacing", 32'(gc - prev_gc), 32'(5));
      prev_gc = gc;
    end
    bus.req_valid = '0;
    step();

    // Reset during WAIT_NEXT discards the request; requester 0 wins after release.
    xs[1] = 8'($urandom);
    bus.req_x[8 +: 8] = xs[1];
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_grant", 32'(bus.req_ready), 32'(4'b0010));
    step();
    step();
    chk("mid_busy", 32'(bus.busy), 32'(1));
    chk("mid_lut_en", 32'(bus.lut_en), 32'(0));
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    step();
    chk("mid_busy_rst", 32'(bus.busy), 32'(0));
    chk("mid_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("mid_req_ready", 32'(bus.req_ready), 32'(0));
    chk("mid_lut_en_rst", 32'(bus.lut_en), 32'(0));
    chk("mid_interp_base", 32'(bus.interp_base), 32'(0));
    chk("mid_resp_data", 32'(bus.resp_data), 32'(0));
    rst = 1'b0;
    run_req(0, xs[0], 1'b0, 1'b0, 8'sd0, gc);
    exp_ptr = 0;
    step();

    // Randomized rounds: random masks, inputs, LUT contents and consumer stalls.
    for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom);
    for (int r = 0; r < 24; r++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        xs[i] = 8'($urandom);
        bus.req_x[8*i +: 8] = xs[i];
      end
      pk = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (pk < 0 && mask[(exp_ptr + k) % NUM_REQ]) pk = (exp_ptr + k) % NUM_REQ;
      end
      exp_ptr = pk;
      bus.resp_ready = 1'b0;
      bus.req_valid = mask;
      run_req(pk, xs[pk], 1'b0, 1'b0, 8'sd0, gc);
      ref_model(xs[pk], a0, rem, ed);
      w = $urandom_range(0, 3);
      for (int j = 0; j < w; j++) begin
        step();
        chk("rnd_hold_valid", 32'(bus.resp_valid), 32'(1));
        chk("rnd_hold_data", 32'(bus.resp_data), 32'(ed));
        chk("rnd_hold_id", 32'(bus.resp_id), 32'(pk));
      end
      bus.resp_ready = 1'b1;
      step();
      chk("rnd_resp_drop", 32'(bus.resp_valid), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

endmodule
